uprog_wcs: RTL and testbench

UPROG_WCS -- requirements
Module: uprog_wcs

---
 rtl/uprog_wcs.sv | 104 ++++++++++
 tb/tb_uprog_wcs.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uprog_wcs.sv
// Writable-control-store micro-programmed FSM.
// The control store is filled through a ready/valid load port, one microword
// per accepted beat, then executed: each cycle the word at {Q, IN} supplies
// the FSM outputs combinationally and the next state on the rising edge.
module uprog_wcs #(
    parameter int S_W = 2,
    parameter int I_W = 2,
    parameter int O_W = 2
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               LD_START,
    input  logic               LD_VALID,
    input  logic [S_W+O_W-1:0] LD_DATA,
    output logic               LD_READY,
    output logic               DONE,
    input  logic [I_W-1:0]     IN,
    output logic [O_W-1:0]     OUT,
    output logic [S_W-1:0]     Q
);

    localparam int D_W   = S_W + O_W;
    localparam int A_W   = S_W + I_W;
    localparam int DEPTH = 1 << A_W;

    localparam logic [1:0] MODE_EMPTY = 2'd0;
    localparam logic [1:0] MODE_LOAD  = 2'd1;
    localparam logic [1:0] MODE_RUN   = 2'd2;

    logic [1:0]     mode;
    logic [A_W-1:0] ptr;
    logic [S_W-1:0] q;
    logic [A_W-1:0] addr;
    logic [D_W-1:0] word;
    logic           wr_en;
    logic [D_W-1:0] mem [DEPTH];

    assign addr     = {q, IN};
    assign word     = mem[addr];
    assign LD_READY = (mode == MODE_LOAD);
    assign DONE     = (mode == MODE_RUN);
    assign Q        = q;
    // A restart request in the same cycle as a valid beat drops that beat.
    assign wr_en    = !CLR && (mode == MODE_LOAD) && !LD_START && LD_VALID;

    // Microword output is only exposed while the table is executing.
    always_comb begin
        OUT = '0;
        if (mode == MODE_RUN) begin
            OUT = word[O_W-1:0];
        end
    end

    // Control store write port; contents are deliberately not cleared by CLR.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[ptr] <= LD_DATA;
        end
    end

    // Mode sequencing, load pointer and FSM state register.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            mode <= MODE_EMPTY;
            ptr  <= '0;
            q    <= '0;
        end else begin
            case (mode)
                MODE_EMPTY: begin
                    if (LD_START) begin
                        mode <= MODE_LOAD;
                        ptr  <= '0;
                    end
                end
                MODE_LOAD: begin
                    if (LD_START) begin
                        ptr <= '0;
                    end else if (LD_VALID) begin
                        ptr <= ptr + 1'b1;
                        if (ptr == '1) begin
                            mode <= MODE_RUN;
                            q    <= '0;
                        end
                    end
                end
                MODE_RUN: begin
                    if (LD_START) begin
                        mode <= MODE_LOAD;
                        ptr  <= '0;
                        q    <= '0;
                    end else begin
                        q <= word[D_W-1:O_W];
                    end
                end
                default: begin
                    mode <= MODE_EMPTY;
                    ptr  <= '0;
                    q    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uprog_wcs.sv
// Directed bench for uprog_wcs with the default 2/2/2 geometry.
module tb_uprog_wcs;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       LD_START;
    logic       LD_VALID;
    logic [3:0] LD_DATA;
    logic       LD_READY;
    logic       DONE;
    logic [1:0] IN;
    logic [1:0] OUT;
    logic [1:0] Q;

    int checks = 0;
    int errors = 0;

    // Table T, word = {next_state, out}, address = {Q, IN}.
    logic [3:0] tbl [16] = '{4'h5, 4'h9, 4'h5, 4'h9,
                             4'hF, 4'hF, 4'hF, 4'hF,
                             4'h4, 4'h4, 4'h8, 4'h8,
                             4'hB, 4'h3, 4'hB, 4'h3};

    uprog_wcs #(.S_W(2), .I_W(2), .O_W(2)) dut (
        .CLK(CLK), .CLR(CLR), .LD_START(LD_START), .LD_VALID(LD_VALID),
        .LD_DATA(LD_DATA), .LD_READY(LD_READY), .DONE(DONE),
        .IN(IN), .OUT(OUT), .Q(Q)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feed n beats starting at table index 0; zero selects an all-zero table.
    task automatic load_words(input int n, input bit zero, input bit gaps);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 200) begin
            LD_VALID = !(gaps && (cyc % 3 == 2));
            LD_DATA  = zero ? 4'h0 : tbl[acc];
            #1;
            chk("load_ready", 32'(LD_READY), 32'd1);
            if (acc > 0 || cyc > 0) chk("load_done_low", 32'(DONE), 32'd0);
            if (zero) chk("load_q_zero", 32'(Q), 32'd0);
            if (LD_VALID) acc++;
            tick();
            cyc++;
        end
        LD_VALID = 1'b0;
        if (cyc >= 200) chk("load_timeout", 32'(acc), 32'(n));
    endtask

    task automatic run_step(input logic [1:0] in_v, input logic [1:0] exp_q,
                            input logic [1:0] exp_out);
        IN = in_v;
        #1;
        chk("run_q", 32'(Q), 32'(exp_q));
        chk("run_out", 32'(OUT), 32'(exp_out));
        tick();
    endtask

    initial begin
        logic [1:0] seq_q [7]   = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11, 2'b10};
        logic [1:0] seq_out [7] = '{2'b01, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00};

        CLR = 1'b1; LD_START = 1'b0; LD_VALID = 1'b0; LD_DATA = '0; IN = '0;
        tick();
        tick();
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_out", 32'(OUT), 32'd0);
        chk("rst_ready", 32'(LD_READY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);

        // Valid beats while EMPTY are ignored.
        CLR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            LD_VALID = 1'b1; LD_DATA = 4'hA;
            tick();
            chk("empty_ready", 32'(LD_READY), 32'd0);
            chk("empty_done", 32'(DONE), 32'd0);
        end
        LD_VALID = 1'b0;

        // Load T with a gap every third cycle.
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        load_words(16, 1'b0, 1'b1);
        chk("loaded_done", 32'(DONE), 32'd1);
        chk("loaded_ready", 32'(LD_READY), 32'd0);
        chk("loaded_q", 32'(Q), 32'd0);

        for (int i = 0; i < 7; i++) run_step(2'b00, seq_q[i], seq_out[i]);
        // Q is now 01; walk to 11 then take the IN[0]=1 exit to 00.
        run_step(2'b00, 2'b01, 2'b11);
        run_step(2'b01, 2'b11, 2'b11);
        run_step(2'b11, 2'b00, 2'b01);
        run_step(2'b11, 2'b10, 2'b00);
        run_step(2'b11, 2'b10, 2'b00);
        run_step(2'b00, 2'b10, 2'b00);
        run_step(2'b00, 2'b01, 2'b11);

        // Reload, abort with CLR after 7 beats.
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        chk("reload_done", 32'(DONE), 32'd0);
        load_words(7, 1'b0, 1'b0);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("clr_done", 32'(DONE), 32'd0);
        chk("clr_ready", 32'(LD_READY), 32'd0);
        chk("clr_q", 32'(Q), 32'd0);

        // Restart mid-load after 5 beats: 16 further beats needed.
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        load_words(5, 1'b1, 1'b0);
        LD_START = 1'b1; LD_VALID = 1'b1; LD_DATA = 4'h6;
        tick();
        LD_START = 1'b0; LD_VALID = 1'b0;
        load_words(15, 1'b0, 1'b0);
        chk("restart_15_done", 32'(DONE), 32'd0);
        chk("restart_15_ready", 32'(LD_READY), 32'd1);
        LD_VALID = 1'b1; LD_DATA = tbl[15];
        tick();
        LD_VALID = 1'b0;
        chk("restart_16_done", 32'(DONE), 32'd1);
        run_step(2'b00, 2'b00, 2'b01);
        run_step(2'b01, 2'b01, 2'b11);

        // Reload from RUN with an all-zero table.
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        chk("zero_start_done", 32'(DONE), 32'd0);
        chk("zero_start_q", 32'(Q), 32'd0);
        load_words(16, 1'b1, 1'b0);
        chk("zero_done", 32'(DONE), 32'd1);
        for (int i = 0; i < 4; i++) run_step(2'(i), 2'b00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
